// File: rtl/tile_clk_rst_seq.sv
// Tile clock/reset sequencer: accepts OFF / ON / RESET commands for one tile
// (or all tiles when broadcast is compiled in) and walks the target through a
// glitch-safe ordering of reset assertion, clock gating and reset release.
//
// Optional feature macro: PICOBELLO_TILE_SEQ_BCAST_EN
//   defined   -> req_bcast_i=1 applies the command to every tile
//   undefined -> req_bcast_i is ignored, no broadcast logic
//
// Ports
//   clk_i          clock
//   rst_i          synchronous active-high reset
//   req_valid_i    command valid
//   req_ready_o    command accepted when valid && ready (IDLE only)
//   req_cmd_i      0=OFF 1=ON 2=RESET 3=reserved
//   req_tile_i     target tile index
//   req_bcast_i    target all tiles (macro dependent)
//   tile_clk_en_o  per-tile clock enable
//   tile_rst_no    per-tile active-low reset
//   done_o         one-cycle completion pulse
//   err_o          command rejected, valid with done_o
module tile_clk_rst_seq #(
  parameter int unsigned NumTiles     = 16,
  parameter int unsigned ClkGapCycles = 4,
  parameter int unsigned RstCycles    = 8,
  localparam int unsigned TileW       = (NumTiles > 1) ? $clog2(NumTiles) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [1:0]          req_cmd_i,
  input  logic [TileW-1:0]    req_tile_i,
  input  logic                req_bcast_i,
  output logic [NumTiles-1:0] tile_clk_en_o,
  output logic [NumTiles-1:0] tile_rst_no,
  output logic                done_o,
  output logic                err_o
);

  localparam logic [1:0] CmdOff   = 2'd0;
  localparam logic [1:0] CmdOn    = 2'd1;
  localparam logic [1:0] CmdRsvd  = 2'd3;
  localparam logic [7:0] GapLoad  = 8'(ClkGapCycles - 1);
  localparam logic [7:0] HoldLoad = 8'(RstCycles - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRE_RST,
    CLK_OFF,
    RST_HOLD,
    DONE
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [1:0]          cmd_q, cmd_d;
  logic [NumTiles-1:0] tgt_q, tgt_d;
  logic                err_q, err_d;
  logic [NumTiles-1:0] en_d, rstn_d;
  logic [NumTiles-1:0] req_tgt_c;
  logic                req_err_c;

  // Decode the incoming request into a target mask and a reject flag
  always_comb begin
    req_tgt_c = '0;
    for (int i = 0; i < NumTiles; i++) begin
      req_tgt_c[i] = (req_tile_i == TileW'(i));
    end
`ifdef PICOBELLO_TILE_SEQ_BCAST_EN
    if (req_bcast_i) req_tgt_c = '1;
    req_err_c = (req_cmd_i == CmdRsvd) ||
                (!req_bcast_i && (32'(req_tile_i) >= NumTiles));
`else
    req_err_c = (req_cmd_i == CmdRsvd) || (32'(req_tile_i) >= NumTiles);
`endif
  end

`ifndef PICOBELLO_TILE_SEQ_BCAST_EN
  logic unused_bcast;
  assign unused_bcast = req_bcast_i;
`endif

  // Next state, counter, latched command, and next tile outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    tgt_d   = tgt_q;
    err_d   = err_q;
    en_d    = tile_clk_en_o;
    rstn_d  = tile_rst_no;

    case (state_q)
      IDLE: begin
        if (req_valid_i && req_ready_o) begin
          cmd_d = req_cmd_i;
          err_d = req_err_c;
          tgt_d = req_err_c ? '0 : req_tgt_c;
          if (req_err_c) begin
            state_d = DONE;
          end else if (req_cmd_i == CmdOn) begin
            state_d = RST_HOLD;
            cnt_d   = HoldLoad;
          end else begin
            state_d = PRE_RST;
            cnt_d   = GapLoad;
          end
        end
      end
      PRE_RST: begin
        if (cnt_q == 8'd0) begin
          state_d = CLK_OFF;
          cnt_d   = GapLoad;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      CLK_OFF: begin
        if (cnt_q == 8'd0) begin
          if (cmd_q == CmdOff) begin
            state_d = DONE;
          end else begin
            state_d = RST_HOLD;
            cnt_d   = HoldLoad;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RST_HOLD: begin
        if (cnt_q == 8'd0) state_d = DONE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs follow the state being entered so they line up with it
    case (state_d)
      PRE_RST: rstn_d = tile_rst_no & ~tgt_d;
      CLK_OFF: begin
        en_d   = tile_clk_en_o & ~tgt_d;
        rstn_d = tile_rst_no & ~tgt_d;
      end
      RST_HOLD: begin
        en_d   = tile_clk_en_o | tgt_d;
        rstn_d = tile_rst_no & ~tgt_d;
      end
      DONE: begin
        // Release only after a hold phase, where the clock is already on
        if (!err_d && (cmd_d != CmdOff)) rstn_d = tile_rst_no | tgt_d;
      end
      default: ;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      cnt_q         <= 8'd0;
      cmd_q         <= CmdOff;
      tgt_q         <= '0;
      err_q         <= 1'b0;
      tile_clk_en_o <= '0;
      tile_rst_no   <= '0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
      req_ready_o   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cmd_q         <= cmd_d;
      tgt_q         <= tgt_d;
      err_q         <= err_d;
      tile_clk_en_o <= en_d;
      tile_rst_no   <= rstn_d;
      done_o        <= (state_d == DONE);
      err_o         <= (state_d == DONE) && err_d;
      req_ready_o   <= (state_d == IDLE);
    end
  end

endmodule

// File: tb/tb_tile_clk_rst_seq.sv
// Bench for tile_clk_rst_seq: directed table, randomized commands against a
// phase-list model, mid-command reset, and out-of-range index on a 5-tile copy.
module tb_tile_clk_rst_seq;

  localparam int unsigned NT = 4;
  localparam int unsigned G  = 2;
  localparam int unsigned R  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid, bcast, ready, done, err;
  logic [1:0]    cmd, tile;
  logic [NT-1:0] en, rstn;

  logic          b_valid, b_bcast, b_ready, b_done, b_err;
  logic [1:0]    b_cmd;
  logic [2:0]    b_tile;
  logic [4:0]    b_en, b_rstn;

  int checks   = 0;
  int failures = 0;

  logic [NT-1:0] m_en, m_rstn, prev_en, prev_rstn;

  always #5 clk = ~clk;

  tile_clk_rst_seq #(.NumTiles(NT), .ClkGapCycles(G), .RstCycles(R)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(valid), .req_ready_o(ready),
    .req_cmd_i(cmd), .req_tile_i(tile), .req_bcast_i(bcast),
    .tile_clk_en_o(en), .tile_rst_no(rstn), .done_o(done), .err_o(err)
  );

  tile_clk_rst_seq #(.NumTiles(5), .ClkGapCycles(G), .RstCycles(R)) dut_b (
    .clk_i(clk), .rst_i(rst), .req_valid_i(b_valid), .req_ready_o(b_ready),
    .req_cmd_i(b_cmd), .req_tile_i(b_tile), .req_bcast_i(b_bcast),
    .tile_clk_en_o(b_en), .tile_rst_no(b_rstn), .done_o(b_done), .err_o(b_err)
  );

  typedef struct {
    logic [1:0]    cmd;
    logic [1:0]    tile;
    logic          bcast;
    int            lat;
    logic          err;
    logic [NT-1:0] en;
    logic [NT-1:0] rstn;
  } vec_t;

  localparam int NV = 9;
  vec_t vt[NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock, sample 1 time unit later, and check the safe-ordering rule
  task automatic step();
    logic bad;
    @(posedge clk);
    #1;
    if (!rst) begin
      bad = 1'b0;
      for (int i = 0; i < NT; i++) begin
        if (!prev_rstn[i] && rstn[i] && !(en[i] && prev_en[i])) bad = 1'b1;
        if (prev_en[i] && !en[i] && (prev_rstn[i] || rstn[i])) bad = 1'b1;
      end
      check("rst_clk_order", 64'(bad), 64'(1'b0));
    end
    prev_en   = en;
    prev_rstn = rstn;
  endtask

  // Issue one command and check every cycle up to completion against the model
  task automatic do_cmd(input logic [1:0] c, input logic [1:0] t, input logic b,
                        output int obs_lat, output logic obs_err);
    logic          be, is_err;
    logic [NT-1:0] tgt, te, tr, exp_en, exp_rstn;
    int            p, cg, h, lat, ph, w;
`ifdef PICOBELLO_TILE_SEQ_BCAST_EN
    be = b;
`else
    be = 1'b0;
`endif
    is_err = (c == 2'd3) || (!be && (32'(t) >= NT));
    tgt    = is_err ? '0 : (be ? {NT{1'b1}} : (NT'(1) << t));
    p      = (c == 2'd0 || c == 2'd2) ? int'(G) : 0;
    cg     = p;
    h      = (c == 2'd1 || c == 2'd2) ? int'(R) : 0;
    lat    = is_err ? 1 : p + cg + h + 1;
    obs_lat = 0;
    obs_err = 1'b0;
    w = 0;
    while (ready !== 1'b1 && w < 20) begin
      step();
      w++;
    end
    check("ready_idle", 64'(ready), 64'(1'b1));
    valid = 1'b1; cmd = c; tile = t; bcast = b;
    step();
    valid = 1'b0; cmd = 2'($urandom); tile = 2'($urandom); bcast = 1'($urandom);
    for (int k = 1; k <= lat; k++) begin
      // phase: 0 pre-reset, 1 clock off, 2 reset hold, 3 done
      ph = (is_err || k == lat) ? 3 : (k <= p) ? 0 : (k <= p + cg) ? 1 : 2;
      case (ph)
        0:       begin te = m_en; tr = '0; end
        1:       begin te = '0;   tr = '0; end
        2:       begin te = '1;   tr = '0; end
        default: begin
          if (is_err)         begin te = m_en; tr = m_rstn; end
          else if (c == 2'd0) begin te = '0;   tr = '0;     end
          else                begin te = '1;   tr = '1;     end
        end
      endcase
      exp_en   = (m_en & ~tgt) | (te & tgt);
      exp_rstn = (m_rstn & ~tgt) | (tr & tgt);
      if (done === 1'b1 && obs_lat == 0) begin
        obs_lat = k;
        obs_err = err;
      end
      check("tile_clk_en", 64'(en), 64'(exp_en));
      check("tile_rst_n", 64'(rstn), 64'(exp_rstn));
      check("done_pulse", 64'(done), 64'(k == lat));
      check("ready_busy", 64'(ready), 64'(1'b0));
      if (k == lat) begin
        check("err_flag", 64'(err), 64'(is_err));
        m_en   = exp_en;
        m_rstn = exp_rstn;
      end
      if (k < lat) step();
    end
    step();
    check("ready_after_done", 64'(ready), 64'(1'b1));
    check("done_one_cycle", 64'(done), 64'(1'b0));
  endtask

  initial begin
    int   lat;
    logic e;

    vt[0] = '{2'd1, 2'd1, 1'b0, 4, 1'b0, 4'b0010, 4'b0010};
    vt[1] = '{2'd0, 2'd1, 1'b0, 5, 1'b0, 4'b0000, 4'b0000};
    vt[2] = '{2'd1, 2'd2, 1'b0, 4, 1'b0, 4'b0100, 4'b0100};
    vt[3] = '{2'd2, 2'd2, 1'b0, 8, 1'b0, 4'b0100, 4'b0100};
    vt[4] = '{2'd3, 2'd0, 1'b0, 1, 1'b1, 4'b0100, 4'b0100};
    vt[5] = '{2'd1, 2'd2, 1'b0, 4, 1'b0, 4'b0100, 4'b0100};
`ifdef PICOBELLO_TILE_SEQ_BCAST_EN
    vt[6] = '{2'd1, 2'd3, 1'b1, 4, 1'b0, 4'b1111, 4'b1111};
    vt[7] = '{2'd0, 2'd0, 1'b0, 5, 1'b0, 4'b1110, 4'b1110};
    vt[8] = '{2'd2, 2'd0, 1'b0, 8, 1'b0, 4'b1111, 4'b1111};
`else
    vt[6] = '{2'd1, 2'd3, 1'b1, 4, 1'b0, 4'b1100, 4'b1100};
    vt[7] = '{2'd0, 2'd0, 1'b0, 5, 1'b0, 4'b1100, 4'b1100};
    vt[8] = '{2'd2, 2'd0, 1'b0, 8, 1'b0, 4'b1101, 4'b1101};
`endif

    rst = 1'b1; valid = 1'b0; cmd = 2'd0; tile = 2'd0; bcast = 1'b0;
    b_valid = 1'b0; b_cmd = 2'd0; b_tile = 3'd0; b_bcast = 1'b0;
    m_en = '0; m_rstn = '0; prev_en = '0; prev_rstn = '0;
    repeat (3) step();
    check("reset_clk_en", 64'(en), 64'(0));
    check("reset_rst_n", 64'(rstn), 64'(0));
    check("reset_ready", 64'(ready), 64'(1'b0));
    check("reset_done", 64'(done), 64'(1'b0));
    rst = 1'b0;
    step();
    check("ready_after_reset", 64'(ready), 64'(1'b1));
    check("err_after_reset", 64'(err), 64'(1'b0));

    for (int i = 0; i < NV; i++) begin
      do_cmd(vt[i].cmd, vt[i].tile, vt[i].bcast, lat, e);
      check("tbl_latency", 64'(lat), 64'(vt[i].lat));
      check("tbl_err", 64'(e), 64'(vt[i].err));
      check("tbl_clk_en", 64'(en), 64'(vt[i].en));
      check("tbl_rst_n", 64'(rstn), 64'(vt[i].rstn));
    end

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) step();
      do_cmd(2'($urandom), 2'($urandom), 1'($urandom), lat, e);
    end

    // Reset arriving while the target clock is gated drops the command
    do_cmd(2'd1, 2'd1, 1'b0, lat, e);
    valid = 1'b1; cmd = 2'd0; tile = 2'd1; bcast = 1'b0;
    step();
    valid = 1'b0;
    repeat (G) step();
    check("abort_in_clk_off", 64'(en[1]), 64'(1'b0));
    rst = 1'b1;
    step();
    check("abort_clk_en", 64'(en), 64'(0));
    check("abort_rst_n", 64'(rstn), 64'(0));
    check("abort_done", 64'(done), 64'(1'b0));
    check("abort_err", 64'(err), 64'(1'b0));
    check("abort_ready", 64'(ready), 64'(1'b0));
    rst = 1'b0;
    m_en = '0; m_rstn = '0;
    for (int k = 0; k < 6; k++) begin
      step();
      check("abort_no_done", 64'(done), 64'(1'b0));
    end
    check("abort_ready_back", 64'(ready), 64'(1'b1));

    // Out-of-range index rejected on the 5-tile instance, last legal index works
    b_valid = 1'b1; b_cmd = 2'd1; b_tile = 3'd5;
    step();
    b_valid = 1'b0;
    check("oor_done", 64'(b_done), 64'(1'b1));
    check("oor_err", 64'(b_err), 64'(1'b1));
    check("oor_clk_en", 64'(b_en), 64'(0));
    check("oor_rst_n", 64'(b_rstn), 64'(0));
    step();
    step();
    check("oor_ready", 64'(b_ready), 64'(1'b1));
    b_valid = 1'b1; b_cmd = 2'd1; b_tile = 3'd4;
    step();
    b_valid = 1'b0;
    for (int k = 1; k <= int'(R) + 1; k++) begin
      check("t4_done", 64'(b_done), 64'(k == int'(R) + 1));
      check("t4_rst_n", 64'(b_rstn), 64'((k == int'(R) + 1) ? 5'b10000 : 5'b00000));
      if (k <= int'(R)) step();
    end
    check("t4_err", 64'(b_err), 64'(1'b0));
    check("t4_clk_en", 64'(b_en), 64'(5'b10000));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
